brick_field: RTL
================

# brick_field

Holds the 15-brick wall, detects ball-versus-brick overlap, and reports the hit to the ball controller. It consumes the ball controller's `ball_x/ball_y/ball_width/ball_height`. It produces the per-brick collision pulses, the hit brick's geometry, `win`, and the brick layer of `vga_color`. Collision checking is a sequential scan, one brick per cycle, so only one comparator set is needed.

## Interface
- `X0`, 5: x of column 0
- `Y0`, 40: y of row 0
- `PITCH_X`, 126: column pitch
- `PITCH_Y`, 40: row pitch
- `BRICK_W`, 120: brick width
- `BRICK_H`, 32: brick height
- `clk`  in  1  system clock, 25 MHz pixel clock. Only clock.
- `rst`  in  1  asynchronous, active-high reset
- `x`, `y`  in  10 each  current VGA pixel
- `active_pixels`  in  1  visible region
- `ball_x`, `ball_y`, `ball_width`, `ball_height`  in  10 each  ball box
- `collide_block`  out  15  one-hot hit pulse. Bit i drives the ball's i-th collide input (bit 0 → `collide_block`, bit 1 → `collide_block2`, …).
- `block_x`, `block_y`  out  10 each  origin of the last brick hit
- `block_width`, `block_height`  out  10 each  `BRICK_W`, `BRICK_H`
- `bricks_left`  out  4  live brick count
- `win`  out  1  all bricks cleared, sticky
- `vga_color`  out  24  brick pixel colour, 0 elsewhere

## Operation
- **Brick geometry**
  - Brick i: row = i/5, col = i%5.
  - bx = X0 + col·PITCH_X; by = Y0 + row·PITCH_Y.
  - `alive[14:0]` tracks which bricks remain.
- **Overlap test:** ball_x < bx+BRICK_W && ball_x+ball_width > bx && ball_y < by+BRICK_H && ball_y+ball_height > by.
  - Evaluate in 11-bit unsigned so sums cannot wrap.
  - Edges that only touch do not collide.
- **FSM states:** SAMPLE, CHECK, HIT, DONE.
  - **SAMPLE** (1 cycle)
    - Latch ball_x and ball_y into smp_x and smp_y.
    - If lock is set and (ball_x, ball_y) ≠ (lock_x, lock_y), clear lock.
    - Set idx = 0; next state is CHECK.
  - **CHECK** (one brick per cycle)
    - If alive[idx] && overlap(smp, idx) && !lock, go to HIT and remember idx.
    - Otherwise, if idx = 14, go to SAMPLE; else idx + 1.
  - **On the edge entering HIT:**
    - collide_block[idx] ← 1; alive[idx] ← 0.
    - block_x, block_y ← that brick's origin.
    - bricks_left ← bricks_left − 1.
    - lock ← 1; (lock_x, lock_y) ← (smp_x, smp_y).
  - **HIT** (1 cycle)
    - On exit, collide_block ← 0.
    - If bricks_left = 0, win ← 1 and go to DONE; else go to SAMPLE.
  - **DONE:** terminal. No further scanning and no pulses. Leave only by reset.
- **Hit rules**
  - At most one brick is removed per ball position; the lock prevents double kills while the ball controller holds its `hit_block`.
  - When several live bricks overlap, the lowest index wins.
- **Render:** combinational, zero latency, matching the ball layer.
  - `active_pixels` = 0 → 0.
  - Pixel inside a live brick → row 0 24'hFF0000, row 1 24'hFFA500, row 2 24'hFFFF00.
  - Else 0.

## Timing
- **Reset values**
  - collide_block = 0, block_x = block_y = 0, block_width = BRICK_W, block_height = BRICK_H.
  - bricks_left = 15, win = 0, alive = all 1, lock = 0.
  - State SAMPLE.
- All outputs are registered except `vga_color`.
- collide_block is high for exactly one cycle (the HIT cycle); block_x and block_y are valid in that same cycle.
- win rises the cycle after the 15th pulse.
- A full pass without a hit takes 16 cycles.
- Pulse latency from a new overlapping ball position: at most 33 cycles. This is far below the ball's move period (≥208 333 cycles).
- Reset asserted mid-pass or during HIT: all state returns to reset values asynchronously; a pulse in flight is dropped.

## Test plan
- **Reset:** assert rst with ball at (300,400) → collide_block = 0, bricks_left = 15, win = 0; pixel (10,45) with `active_pixels` = 1 → 24'hFF0000.
- **Single hit:** ball at (40,50), 20×20 → one pulse on bit 0 within 33 cycles, block_x = 5, block_y = 40, bricks_left = 14; pixel (10,45) → 0.
- **Lockout and lowest index:** ball held at (120,50), overlapping bricks 0 and 1, for 2000 cycles → exactly one pulse, bit 0. Move ball to (121,50) → one pulse on bit 1.
- **Touching edge:** ball at (105,20), so ball bottom = brick 0 top → no pulse for 200 cycles; bricks_left unchanged.
- **Win:** walk the ball over all 15 bricks → 15 pulses, one per bit; win = 1 one cycle after the last pulse. Win stays high, and pulses stay 0 for 500 more cycles of overlapping positions.
- **Reset mid-HIT:** assert rst during a HIT cycle → collide_block = 0 at once, bricks_left = 15, all bricks render again.

Source files
------------

// File: rtl/brick_field.sv
// Brick wall for the breakout game: tracks live bricks, scans one brick per
// cycle for ball overlap, emits one-hot hit pulses and renders the brick layer.
module brick_field #(
  parameter int unsigned X0      = 5,
  parameter int unsigned Y0      = 40,
  parameter int unsigned PITCH_X = 126,
  parameter int unsigned PITCH_Y = 40,
  parameter int unsigned BRICK_W = 120,
  parameter int unsigned BRICK_H = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  ball_width,
  input  logic [9:0]  ball_height,
  output logic [14:0] collide_block,
  output logic [9:0]  block_x,
  output logic [9:0]  block_y,
  output logic [9:0]  block_width,
  output logic [9:0]  block_height,
  output logic [3:0]  bricks_left,
  output logic        win,
  output logic [23:0] vga_color
);

  typedef enum logic [1:0] {SAMPLE, CHECK, HIT, DONE} state_t;

  function automatic logic [1:0] brick_row(input logic [3:0] i);
    return (i >= 4'd10) ? 2'd2 : (i >= 4'd5) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [10:0] brick_bx(input logic [3:0] i);
    logic [3:0] col;
    col = (i >= 4'd10) ? i - 4'd10 : (i >= 4'd5) ? i - 4'd5 : i;
    return 11'(X0 + col * PITCH_X);
  endfunction

  function automatic logic [10:0] brick_by(input logic [3:0] i);
    return 11'(Y0 + brick_row(i) * PITCH_Y);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [14:0] alive_q, alive_d;
  logic        lock_q, lock_d;
  logic [9:0]  lock_x_q, lock_x_d, lock_y_q, lock_y_d;
  logic [9:0]  smp_x_q, smp_x_d, smp_y_q, smp_y_d;
  logic [14:0] collide_q, collide_d;
  logic [9:0]  block_x_q, block_x_d, block_y_q, block_y_d;
  logic [3:0]  bricks_left_q, bricks_left_d;
  logic        win_q, win_d;

  logic [10:0] cur_bx, cur_by;
  logic        overlap;

  always_comb begin
    cur_bx  = brick_bx(idx_q);
    cur_by  = brick_by(idx_q);
    // 11-bit compare so box right/bottom sums never wrap
    overlap = ({1'b0, smp_x_q} < cur_bx + 11'(BRICK_W)) &&
              ({1'b0, smp_x_q} + {1'b0, ball_width} > cur_bx) &&
              ({1'b0, smp_y_q} < cur_by + 11'(BRICK_H)) &&
              ({1'b0, smp_y_q} + {1'b0, ball_height} > cur_by);

    state_d       = state_q;
    idx_d         = idx_q;
    alive_d       = alive_q;
    lock_d        = lock_q;
    lock_x_d      = lock_x_q;
    lock_y_d      = lock_y_q;
    smp_x_d       = smp_x_q;
    smp_y_d       = smp_y_q;
    collide_d     = '0;
    block_x_d     = block_x_q;
    block_y_d     = block_y_q;
    bricks_left_d = bricks_left_q;
    win_d         = win_q;

    unique case (state_q)
      SAMPLE: begin
        smp_x_d = ball_x;
        smp_y_d = ball_y;
        if (lock_q && (ball_x != lock_x_q || ball_y != lock_y_q)) lock_d = 1'b0;
        idx_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (alive_q[idx_q] && overlap && !lock_q) begin
          state_d         = HIT;
          collide_d       = 15'(1) << idx_q;
          alive_d[idx_q]  = 1'b0;
          block_x_d       = cur_bx[9:0];
          block_y_d       = cur_by[9:0];
          bricks_left_d   = bricks_left_q - 4'd1;
          lock_d          = 1'b1;
          lock_x_d        = smp_x_q;
          lock_y_d        = smp_y_q;
        end else if (idx_q == 4'd14) begin
          state_d = SAMPLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      HIT: begin
        if (bricks_left_q == 4'd0) begin
          win_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SAMPLE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = SAMPLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SAMPLE;
      idx_q         <= '0;
      alive_q       <= '1;
      lock_q        <= 1'b0;
      lock_x_q      <= '0;
      lock_y_q      <= '0;
      smp_x_q       <= '0;
      smp_y_q       <= '0;
      collide_q     <= '0;
      block_x_q     <= '0;
      block_y_q     <= '0;
      bricks_left_q <= 4'd15;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      alive_q       <= alive_d;
      lock_q        <= lock_d;
      lock_x_q      <= lock_x_d;
      lock_y_q      <= lock_y_d;
      smp_x_q       <= smp_x_d;
      smp_y_q       <= smp_y_d;
      collide_q     <= collide_d;
      block_x_q     <= block_x_d;
      block_y_q     <= block_y_d;
      bricks_left_q <= bricks_left_d;
      win_q         <= win_d;
    end
  end

  always_comb begin
    vga_color = '0;
    if (active_pixels) begin
      for (int unsigned i = 0; i < 15; i++) begin
        if (alive_q[i] &&
            {1'b0, x} >= brick_bx(4'(i)) && {1'b0, x} < brick_bx(4'(i)) + 11'(BRICK_W) &&
            {1'b0, y} >= brick_by(4'(i)) && {1'b0, y} < brick_by(4'(i)) + 11'(BRICK_H)) begin
          unique case (brick_row(4'(i)))
            2'd0:    vga_color = 24'hFF0000;
            2'd1:    vga_color = 24'hFFA500;
            default: vga_color = 24'hFFFF00;
          endcase
        end
      end
    end
  end

  assign collide_block = collide_q;
  assign block_x       = block_x_q;
  assign block_y       = block_y_q;
  assign block_width   = 10'(BRICK_W);
  assign block_height  = 10'(BRICK_H);
  assign bricks_left   = bricks_left_q;
  assign win           = win_q;

endmodule
